multicycle_ctrl: RTL and testbench



---
 rtl/rv_ctrl_pkg.sv | 43 ++++
 rtl/mem_wait_timer.sv | 34 +++
 rtl/multicycle_ctrl.sv | 158 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared RV32I control encodings: opcodes, FSM states and
// datapath mux select values used by decoder, datapath and control.
package rv_ctrl_pkg;

  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] BTYPE    = 7'b1100011;
  localparam logic [6:0] LOADS    = 7'b0000011;
  localparam logic [6:0] STORES   = 7'b0100011;
  localparam logic [6:0] ARITHM_I = 7'b0010011;
  localparam logic [6:0] ARITHM_R = 7'b0110011;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [1:0] PC_PLUS4   = 2'd0;
  localparam logic [1:0] PC_IMM     = 2'd1;
  localparam logic [1:0] PC_RS1_IMM = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  localparam logic ADDR_PC  = 1'b0;
  localparam logic ADDR_ALU = 1'b1;

  localparam logic [2:0] SIZE_WORD = 3'b010;

  function automatic logic is_known(input logic [6:0] op);
    return op inside {LUI, AUIPC, JAL, JALR, BTYPE,
                      LOADS, STORES, ARITHM_I, ARITHM_R};
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory request cycles without ready and flags the cycle
// in which the wait reaches MEM_TIMEOUT (0 disables the timeout).
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic ready,
  output logic expired
);

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !req || ready)
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

  generate
    if (MEM_TIMEOUT > 0) begin : g_to
      // Expire on the edge that would push the count to the limit
      assign expired = req && !ready &&
        (({1'b0, cnt} + (CW+1)'(1)) == (CW+1)'(MEM_TIMEOUT));
    end else begin : g_no_to
      assign expired = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB.
// Define CTRL_ILLEGAL_HALT_EN to halt on unknown opcodes.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] OPCODE,
  input  logic [2:0] FUNCT3,
  input  logic       BR_TAKEN,
  input  logic       MEM_READY,
  output logic       MEM_REQ,
  output logic       MEM_WE,
  output logic [2:0] MEM_SIZE,
  output logic       ADDR_SEL,
  output logic       IR_WE,
  output logic       PC_WE,
  output logic [1:0] PC_SEL,
  output logic       REG_WE,
  output logic [1:0] WB_SEL,
  output logic       ALU_A_SEL,
  output logic       ALU_B_SEL,
  output logic       HALTED
);

  import rv_ctrl_pkg::*;

  state_t state;
  state_t state_nxt;
  logic   halted;
  logic   timeout;
  logic   req_st;

  logic op_lui, op_auipc, op_jal, op_jalr;
  logic op_br, op_ld, op_st, op_i, op_r;

  assign op_lui   = OPCODE == LUI;
  assign op_auipc = OPCODE == AUIPC;
  assign op_jal   = OPCODE == JAL;
  assign op_jalr  = OPCODE == JALR;
  assign op_br    = OPCODE == BTYPE;
  assign op_ld    = OPCODE == LOADS;
  assign op_st    = OPCODE == STORES;
  assign op_i     = OPCODE == ARITHM_I;
  assign op_r     = OPCODE == ARITHM_R;

  assign req_st = (state == S_FETCH) || (state == S_MEM);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk    (CLK),
    .rst    (RST),
    .req    (req_st),
    .ready  (MEM_READY),
    .expired(timeout)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_FETCH: begin
        if (MEM_READY)    state_nxt = S_DECODE;
        else if (timeout) state_nxt = S_HALT;
      end
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        unique case (1'b1)
          op_ld, op_st: state_nxt = S_MEM;
          op_br:        state_nxt = S_FETCH;
          op_r, op_i, op_lui, op_auipc,
          op_jal, op_jalr: state_nxt = S_WB;
`ifdef CTRL_ILLEGAL_HALT_EN
          default:      state_nxt = S_HALT;
`else
          default:      state_nxt = S_FETCH;
`endif
        endcase
      end
      S_MEM: begin
        if (MEM_READY)    state_nxt = op_st ? S_FETCH : S_WB;
        else if (timeout) state_nxt = S_HALT;
      end
      S_WB:    state_nxt = S_FETCH;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= S_FETCH;
      halted <= 1'b0;
    end else begin
      state  <= state_nxt;
      halted <= halted || (state_nxt == S_HALT);
    end
  end

  always_comb begin
    MEM_REQ   = 1'b0;
    MEM_WE    = 1'b0;
    MEM_SIZE  = 3'b000;
    ADDR_SEL  = ADDR_PC;
    IR_WE     = 1'b0;
    PC_WE     = 1'b0;
    PC_SEL    = PC_PLUS4;
    REG_WE    = 1'b0;
    WB_SEL    = WB_ALU;
    ALU_A_SEL = 1'b0;
    ALU_B_SEL = 1'b0;
    HALTED    = 1'b0;
    if (!RST) begin
      unique case (state)
        S_FETCH: begin
          MEM_REQ  = 1'b1;
          MEM_SIZE = SIZE_WORD;
          IR_WE    = MEM_READY;
        end
        S_EXEC: begin
          ALU_A_SEL = op_auipc;
          ALU_B_SEL = is_known(OPCODE) && !op_r && !op_br;
          if (op_br) begin
            PC_WE  = 1'b1;
            PC_SEL = BR_TAKEN ? PC_IMM : PC_PLUS4;
          end
`ifndef CTRL_ILLEGAL_HALT_EN
          else if (!is_known(OPCODE)) begin
            PC_WE = 1'b1;
          end
`endif
        end
        S_MEM: begin
          MEM_REQ  = 1'b1;
          ADDR_SEL = ADDR_ALU;
          MEM_WE   = op_st;
          MEM_SIZE = FUNCT3;
          PC_WE    = op_st && MEM_READY;
        end
        S_WB: begin
          REG_WE = 1'b1;
          PC_WE  = 1'b1;
          unique case (1'b1)
            op_ld:            WB_SEL = WB_MEM;
            op_jal, op_jalr:  WB_SEL = WB_PC4;
            op_lui:           WB_SEL = WB_IMM;
            default:          WB_SEL = WB_ALU;
          endcase
          PC_SEL = op_jal  ? PC_IMM :
                   op_jalr ? PC_RS1_IMM : PC_PLUS4;
        end
        S_HALT:  HALTED = halted;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl.
// Output bundle order: req we size asel irwe pcwe pcsel rwe wbsel a b halted.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'b0010011;
  logic [2:0] funct3 = 3'b000;
  logic       br_taken = 1'b0;
  logic       mem_ready = 1'b0;

  logic       mem_req, mem_we, addr_sel, ir_we, pc_we;
  logic       reg_we, alu_a_sel, alu_b_sel, halted;
  logic [2:0] mem_size;
  logic [1:0] pc_sel, wb_sel;
  logic [15:0] ctrl;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
    .CLK(clk), .RST(rst), .OPCODE(opcode), .FUNCT3(funct3),
    .BR_TAKEN(br_taken), .MEM_READY(mem_ready),
    .MEM_REQ(mem_req), .MEM_WE(mem_we), .MEM_SIZE(mem_size),
    .ADDR_SEL(addr_sel), .IR_WE(ir_we), .PC_WE(pc_we),
    .PC_SEL(pc_sel), .REG_WE(reg_we), .WB_SEL(wb_sel),
    .ALU_A_SEL(alu_a_sel), .ALU_B_SEL(alu_b_sel), .HALTED(halted)
  );

  assign ctrl = {mem_req, mem_we, mem_size, addr_sel, ir_we, pc_we,
                 pc_sel, reg_we, wb_sel, alu_a_sel, alu_b_sel, halted};

  function automatic logic [15:0] ev(
    input logic req, input logic we, input logic [2:0] sz,
    input logic as, input logic irwe, input logic pcwe,
    input logic [1:0] pcs, input logic rwe, input logic [1:0] wbs,
    input logic a, input logic b, input logic h);
    return {req, we, sz, as, irwe, pcwe, pcs, rwe, wbs, a, b, h};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    br_taken = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] exp;
    rst = 1'b1;
    mem_ready = 1'b1;
    opcode = 7'b0110111;
    tick();
    tick();
    #1;
    exp = 16'h0000;
    if (ctrl !== exp) begin
      $display("FAIL reset_out got=%h exp=%h", ctrl, exp);
      failures++;
    end
    checks++;
    rst = 1'b0;
    #1;
    exp = ev(1,0,3'b010,0,1,0,2'd0,0,2'd0,0,0,0);
    if (ctrl !== exp) begin
      $display("FAIL reset_first_fetch got=%h exp=%h", ctrl, exp);
      failures++;
    end
    checks++;
  endtask

  task automatic test_addi();
    logic [15:0] exp;
    do_reset();
    opcode = 7'b0010011;
    funct3 = 3'b000;
    mem_ready = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      #1;
      case (c)
        1, 5:    exp = ev(1,0,3'b010,0,1,0,2'd0,0,2'd0,0,0,0);
        2:       exp = 16'h0000;
        3:       exp = ev(0,0,3'b000,0,0,0,2'd0,0,2'd0,0,1,0);
        default: exp = ev(0,0,3'b000,0,0,1,2'd0,1,2'd0,0,0,0);
      endcase
      if (ctrl !== exp) begin
        $display("FAIL addi_c%0d got=%h exp=%h", c, ctrl, exp);
        failures++;
      end
      checks++;
      tick();
    end
  endtask

  task automatic test_lw_wait();
    logic [15:0] exp;
    do_reset();
    opcode = 7'b0000011;
    funct3 = 3'b010;
    for (int c = 1; c <= 12; c++) begin
      mem_ready = (c == 4 || c == 5 || c == 10 || c == 12);
      #1;
      case (c)
        1, 2, 3: exp = ev(1,0,3'b010,0,0,0,2'd0,0,2'd0,0,0,0);
        4, 12:   exp = ev(1,0,3'b010,0,1,0,2'd0,0,2'd0,0,0,0);
        5:       exp = 16'h0000;
        6:       exp = ev(0,0,3'b000,0,0,0,2'd0,0,2'd0,0,1,0);
        7, 8, 9, 10:
                 exp = ev(1,0,3'b010,1,0,0,2'd0,0,2'd0,0,0,0);
        default: exp = ev(0,0,3'b000,0,0,1,2'd0,1,2'd1,0,0,0);
      endcase
      if (ctrl !== exp) begin
        $display("FAIL lw_c%0d got=%h exp=%h", c, ctrl, exp);
        failures++;
      end
      checks++;
      tick();
    end
  endtask

  task automatic test_branch();
    logic [15:0] exp;
    do_reset();
    opcode = 7'b1100011;
    funct3 = 3'b000;
    mem_ready = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      br_taken = (c <= 3);
      #1;
      case (c)
        1, 4, 7: exp = ev(1,0,3'b010,0,1,0,2'd0,0,2'd0,0,0,0);
        2, 5:    exp = 16'h0000;
        3:       exp = ev(0,0,3'b000,0,0,1,2'd1,0,2'd0,0,0,0);
        default: exp = ev(0,0,3'b000,0,0,1,2'd0,0,2'd0,0,0,0);
      endcase
      if (ctrl !== exp) begin
        $display("FAIL beq_c%0d got=%h exp=%h", c, ctrl, exp);
        failures++;
      end
      checks++;
      tick();
    end
    br_taken = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [6:0]  ops [5] = '{7'b0110011, 7'b0110111, 7'b0010111,
                             7'b1101111, 7'b1100111};
    logic [15:0] ex_e [5];
    logic [15:0] ex_w [5];
    ex_e[0] = ev(0,0,3'b000,0,0,0,2'd0,0,2'd0,0,0,0);
    ex_e[1] = ev(0,0,3'b000,0,0,0,2'd0,0,2'd0,0,1,0);
    ex_e[2] = ev(0,0,3'b000,0,0,0,2'd0,0,2'd0,1,1,0);
    ex_e[3] = ex_e[1];
    ex_e[4] = ex_e[1];
    ex_w[0] = ev(0,0,3'b000,0,0,1,2'd0,1,2'd0,0,0,0);
    ex_w[1] = ev(0,0,3'b000,0,0,1,2'd0,1,2'd3,0,0,0);
    ex_w[2] = ex_w[0];
    ex_w[3] = ev(0,0,3'b000,0,0,1,2'd1,1,2'd2,0,0,0);
    ex_w[4] = ev(0,0,3'b000,0,0,1,2'd2,1,2'd2,0,0,0);
    do_reset();
    mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      opcode = ops[i];
      tick();
      tick();
      #1;
      if (ctrl !== ex_e[i]) begin
        $display("FAIL b2b_exec_%0d got=%h exp=%h", i, ctrl, ex_e[i]);
        failures++;
      end
      checks++;
      tick();
      #1;
      if (ctrl !== ex_w[i]) begin
        $display("FAIL b2b_wb_%0d got=%h exp=%h", i, ctrl, ex_w[i]);
        failures++;
      end
      checks++;
      tick();
    end
  endtask

  task automatic test_store();
    logic [15:0] exp;
    do_reset();
    opcode = 7'b0100011;
    funct3 = 3'b001;
    mem_ready = 1'b1;
    tick();
    tick();
    #1;
    exp = ev(0,0,3'b000,0,0,0,2'd0,0,2'd0,0,1,0);
    if (ctrl !== exp) begin
      $display("FAIL sw_exec got=%h exp=%h", ctrl, exp);
      failures++;
    end
    checks++;
    tick();
    #1;
    exp = ev(1,1,3'b001,1,0,1,2'd0,0,2'd0,0,0,0);
    if (ctrl !== exp) begin
      $display("FAIL sw_mem got=%h exp=%h", ctrl, exp);
      failures++;
    end
    checks++;
    tick();
    #1;
    exp = ev(1,0,3'b010,0,1,0,2'd0,0,2'd0,0,0,0);
    if (ctrl !== exp) begin
      $display("FAIL sw_refetch got=%h exp=%h", ctrl, exp);
      failures++;
    end
    checks++;
  endtask

  task automatic test_timeout();
    logic [15:0] exp;
    do_reset();
    opcode = 7'b0010011;
    for (int c = 1; c <= 7; c++) begin
      mem_ready = (c >= 5);
      #1;
      if (c <= 4) exp = ev(1,0,3'b010,0,0,0,2'd0,0,2'd0,0,0,0);
      else        exp = ev(0,0,3'b000,0,0,0,2'd0,0,2'd0,0,0,1);
      if (ctrl !== exp) begin
        $display("FAIL timeout_c%0d got=%h exp=%h", c, ctrl, exp);
        failures++;
      end
      checks++;
      tick();
    end
    rst = 1'b1;
    #1;
    if (ctrl !== 16'h0000) begin
      $display("FAIL timeout_rst got=%h exp=0000", ctrl);
      failures++;
    end
    checks++;
    tick();
    rst = 1'b0;
    mem_ready = 1'b0;
    #1;
    exp = ev(1,0,3'b010,0,0,0,2'd0,0,2'd0,0,0,0);
    if (ctrl !== exp) begin
      $display("FAIL timeout_clear got=%h exp=%h", ctrl, exp);
      failures++;
    end
    checks++;
  endtask

  task automatic test_illegal();
    logic [15:0] e3;
    logic [15:0] e4;
    do_reset();
    opcode = 7'b1111111;
    mem_ready = 1'b1;
`ifdef CTRL_ILLEGAL_HALT_EN
    e3 = 16'h0000;
    e4 = ev(0,0,3'b000,0,0,0,2'd0,0,2'd0,0,0,1);
`else
    e3 = ev(0,0,3'b000,0,0,1,2'd0,0,2'd0,0,0,0);
    e4 = ev(1,0,3'b010,0,1,0,2'd0,0,2'd0,0,0,0);
`endif
    tick();
    tick();
    #1;
    if (ctrl !== e3) begin
      $display("FAIL illegal_exec got=%h exp=%h", ctrl, e3);
      failures++;
    end
    checks++;
    tick();
    #1;
    if (ctrl !== e4) begin
      $display("FAIL illegal_next got=%h exp=%h", ctrl, e4);
      failures++;
    end
    checks++;
  endtask

  task automatic test_rst_mid_mem();
    logic [15:0] exp;
    do_reset();
    opcode = 7'b0000011;
    funct3 = 3'b100;
    mem_ready = 1'b1;
    tick();
    tick();
    tick();
    mem_ready = 1'b0;
    #1;
    exp = ev(1,0,3'b100,1,0,0,2'd0,0,2'd0,0,0,0);
    if (ctrl !== exp) begin
      $display("FAIL midmem_wait got=%h exp=%h", ctrl, exp);
      failures++;
    end
    checks++;
    tick();
    rst = 1'b1;
    #1;
    if (ctrl !== 16'h0000) begin
      $display("FAIL midmem_rst got=%h exp=0000", ctrl);
      failures++;
    end
    checks++;
    tick();
    rst = 1'b0;
    mem_ready = 1'b1;
    #1;
    exp = ev(1,0,3'b010,0,1,0,2'd0,0,2'd0,0,0,0);
    if (ctrl !== exp) begin
      $display("FAIL midmem_refetch got=%h exp=%h", ctrl, exp);
      failures++;
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_lw_wait();
    test_branch();
    test_back_to_back();
    test_store();
    test_timeout();
    test_illegal();
    test_rst_mid_mem();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
